// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared memory-side definitions for the dcache miss path: block address,
// block data and memory request type.
package dcache_miss_ctrl_pkg;

  localparam int MAIN_MEM_BLOCK_ADDR_W = 26;
  localparam int BLOCK_DATA_W          = 128;

  typedef logic [MAIN_MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_W-1:0]          block_data_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

endpackage

// File: rtl/dcache_miss_timer.sv
// FILL_WAIT watchdog: clears on entry, counts while active, flags expiry on the
// last allowed cycle. Instantiated only when DCACHE_MISS_TIMEOUT_EN is defined.
module dcache_miss_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear on entry, advance while waiting, otherwise hold
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (active_i) begin
      count_d = count_q + CNT_W'(32'd1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count reaches TIMEOUT_CYCLES at the end of this cycle
  assign expired_o = active_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Dcache miss controller: optional victim writeback, block fill request, one-cycle fill pulse.
// Optional FILL_WAIT watchdog is built when the macro DCACHE_MISS_TIMEOUT_EN is defined.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  main_mem_block_addr_t miss_fill_addr,
  input  logic                 miss_wb_valid,
  input  main_mem_block_addr_t miss_wb_addr,
  input  block_data_t          miss_wb_data,
  output logic                 fill_valid,
  output main_mem_block_addr_t fill_addr,
  output block_data_t          fill_data,
  output logic                 req_valid,
  output req_type_t            req_type,
  output main_mem_block_addr_t req_block_addr,
  output block_data_t          req_block_data,
  input  logic                 req_ready,
  input  logic                 resp_valid,
  input  block_data_t          resp_block_data,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e               state_q;
  main_mem_block_addr_t miss_addr_q;
  main_mem_block_addr_t req_addr_q;
  main_mem_block_addr_t fill_addr_q;
  block_data_t          req_data_q;
  block_data_t          fill_data_q;
  req_type_t            req_type_q;
  logic                 miss_ready_q;
  logic                 req_valid_q;
  logic                 fill_valid_q;
  logic                 busy_q;
  logic                 timeout_s;

`ifdef DCACHE_MISS_TIMEOUT_EN
  logic timer_clear_s;
  logic timer_active_s;
  logic timer_expired_s;
  logic timeout_err_q;

  assign timer_clear_s  = (state_q == FILL_REQ) && req_ready;
  assign timer_active_s = (state_q == FILL_WAIT);
  // A response arriving on the expiry cycle still wins
  assign timeout_s      = timer_expired_s && !resp_valid;

  dcache_miss_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear_s),
    .active_i (timer_active_s),
    .expired_o(timer_expired_s)
  );

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_q <= 1'b1;
    end else begin
      timeout_err_q <= timeout_err_q;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic [31:0] timeout_cycles_unused_s;
  assign timeout_cycles_unused_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s               = 1'b0;
  assign timeout_err             = 1'b0;
`endif

  // Miss FSM; every output is loaded together with the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      req_type_q   <= REQ_READ;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      miss_addr_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      fill_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid && miss_ready_q) begin
            miss_addr_q  <= miss_fill_addr;
            miss_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            req_valid_q  <= 1'b1;
            if (miss_wb_valid) begin
              state_q    <= WB_REQ;
              req_type_q <= REQ_WRITE;
              req_addr_q <= miss_wb_addr;
              req_data_q <= miss_wb_data;
            end else begin
              state_q    <= FILL_REQ;
              req_type_q <= REQ_READ;
              req_addr_q <= miss_fill_addr;
              req_data_q <= '0;
            end
          end
        end
        WB_REQ: begin
          if (req_ready) begin
            state_q    <= FILL_REQ;
            req_type_q <= REQ_READ;
            req_addr_q <= miss_addr_q;
            req_data_q <= '0;
          end
        end
        FILL_REQ: begin
          if (req_ready) begin
            state_q     <= FILL_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (resp_valid) begin
            state_q      <= RESP;
            fill_valid_q <= 1'b1;
            fill_addr_q  <= miss_addr_q;
            fill_data_q  <= resp_block_data;
          end else if (timeout_s) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            miss_ready_q <= 1'b1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          miss_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          req_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          miss_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign miss_ready     = miss_ready_q;
  assign busy           = busy_q;
  assign req_valid      = req_valid_q;
  assign req_type       = req_type_q;
  assign req_block_addr = req_addr_q;
  assign req_block_data = req_data_q;
  assign fill_valid     = fill_valid_q;
  assign fill_addr      = fill_addr_q;
  assign fill_data      = fill_data_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed scenarios plus randomized misses checked against a
// transaction-level model (expected request list, fill contents, fill latency from acceptance).
module tb_dcache_miss_ctrl;
  import dcache_miss_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 miss_valid;
  logic                 miss_ready;
  main_mem_block_addr_t miss_fill_addr;
  logic                 miss_wb_valid;
  main_mem_block_addr_t miss_wb_addr;
  block_data_t          miss_wb_data;
  logic                 fill_valid;
  main_mem_block_addr_t fill_addr;
  block_data_t          fill_data;
  logic                 req_valid;
  req_type_t            req_type;
  main_mem_block_addr_t req_block_addr;
  block_data_t          req_block_data;
  logic                 req_ready;
  logic                 resp_valid;
  block_data_t          resp_block_data;
  logic                 busy;
  logic                 timeout_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  dcache_miss_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_fill_addr(miss_fill_addr),
    .miss_wb_valid(miss_wb_valid), .miss_wb_addr(miss_wb_addr), .miss_wb_data(miss_wb_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .req_valid(req_valid), .req_type(req_type), .req_block_addr(req_block_addr),
    .req_block_data(req_block_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_block_data(resp_block_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic block_data_t rand_data();
    block_data_t v;
    for (int i = 0; i < BLOCK_DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic main_mem_block_addr_t rand_addr();
    return main_mem_block_addr_t'($urandom);
  endfunction

  // One full miss transaction; latency model: accept at 0, +1+ws for a writeback,
  // +1+fs for the read request, d idle FILL_WAIT cycles, fill pulse one cycle after the response.
  task automatic run_miss(input string name, input logic dirty,
                          input main_mem_block_addr_t wba, input block_data_t wbd,
                          input main_mem_block_addr_t fa, input int ws, input int fs,
                          input int d, input block_data_t rd);
    req_type_t            exp_t[2];
    main_mem_block_addr_t exp_a[2];
    block_data_t          exp_d[2];
    int                   exp_stall[2];
    int exp_n, exp_lat, ridx, stall, hs_read, acc_cyc, fill_cyc, waitc;
    bit got_fill;
    exp_t[1] = REQ_READ; exp_a[1] = '0; exp_d[1] = '0; exp_stall[1] = 0;
    if (dirty) begin
      exp_n = 2;
      exp_t[0] = REQ_WRITE; exp_a[0] = wba; exp_d[0] = wbd; exp_stall[0] = ws;
      exp_t[1] = REQ_READ;  exp_a[1] = fa;  exp_d[1] = '0;  exp_stall[1] = fs;
    end else begin
      exp_n = 1;
      exp_t[0] = REQ_READ; exp_a[0] = fa; exp_d[0] = '0; exp_stall[0] = fs;
    end
    exp_lat = (dirty ? 1 + ws : 0) + fs + d + 3;

    waitc = 0;
    while (miss_ready !== 1'b1 && waitc < 50) begin tick(); waitc++; end
    tests++;
    if (miss_ready !== 1'b1) begin
      fails++; $display("FAIL %s idle_wait: miss_ready=%b required 1", name, miss_ready);
    end
    miss_valid = 1'b1; miss_wb_valid = dirty; miss_wb_addr = wba;
    miss_wb_data = wbd; miss_fill_addr = fa;
    acc_cyc = cyc;
    tick();
    miss_valid = 1'b0; miss_wb_valid = 1'($urandom); miss_wb_addr = rand_addr();
    miss_wb_data = rand_data(); miss_fill_addr = rand_addr();

    ridx = 0; stall = 0; hs_read = -1; got_fill = 1'b0; fill_cyc = -1;
    for (int c = 0; c < 300 && !got_fill; c++) begin
      if (hs_read >= 0 && cyc > hs_read) resp_valid = (cyc == hs_read + 1 + d);
      else resp_valid = 1'($urandom & 32'd1);
      resp_block_data = (hs_read >= 0 && cyc == hs_read + 1 + d) ? rd : rand_data();
      tests++;
      if (miss_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL %s busy_flags: miss_ready=%b busy=%b required 0 and 1", name, miss_ready, busy);
      end
      if (fill_valid === 1'b1) begin
        got_fill = 1'b1; fill_cyc = cyc;
        tests++;
        if (fill_addr !== fa) begin
          fails++; $display("FAIL %s fill_addr: got %h required %h", name, fill_addr, fa);
        end
        tests++;
        if (fill_data !== rd) begin
          fails++; $display("FAIL %s fill_data: got %h required %h", name, fill_data, rd);
        end
      end
      if (req_valid === 1'b1) begin
        tests++;
        if (ridx >= exp_n) begin
          fails++; req_ready = 1'b0;
          $display("FAIL %s extra_req: got request %0d required only %0d", name, ridx + 1, exp_n);
        end else begin
          if (req_type !== exp_t[ridx] || req_block_addr !== exp_a[ridx] ||
              req_block_data !== exp_d[ridx]) begin
            fails++;
            $display("FAIL %s req%0d: got type=%b addr=%h data=%h required type=%b addr=%h data=%h",
                     name, ridx, req_type, req_block_addr, req_block_data,
                     exp_t[ridx], exp_a[ridx], exp_d[ridx]);
          end
          if (stall < exp_stall[ridx]) begin
            req_ready = 1'b0; stall++;
          end else begin
            req_ready = 1'b1;
            if (exp_t[ridx] == REQ_READ) hs_read = cyc;
            ridx++; stall = 0;
          end
        end
      end else begin
        req_ready = 1'($urandom & 32'd1);
      end
      tick();
    end
    resp_valid = 1'b0; req_ready = 1'b0;
    tests++;
    if (!got_fill) begin
      fails++; $display("FAIL %s fill_seen: got none required one fill pulse", name);
    end
    tests++;
    if (ridx != exp_n) begin
      fails++; $display("FAIL %s req_count: got %0d required %0d", name, ridx, exp_n);
    end
    tests++;
    if (fill_cyc - acc_cyc != exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d required %0d", name, fill_cyc - acc_cyc, exp_lat);
    end
    tests++;
    if (fill_valid !== 1'b0 || busy !== 1'b0 || miss_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s after_fill: fill_valid=%b busy=%b miss_ready=%b required 0 0 1",
               name, fill_valid, busy, miss_ready);
    end
    tests++;
    if (fill_addr !== fa || fill_data !== rd) begin
      fails++; $display("FAIL %s fill_hold: got %h/%h required %h/%h", name, fill_addr, fill_data, fa, rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_valid = 1'b1; miss_wb_valid = 1'b1; req_ready = 1'b1;
    resp_valid = 1'b1; resp_block_data = rand_data();
    tick(); tick();
    tests++;
    if ({req_valid, fill_valid, busy, timeout_err, miss_ready, req_type} !== 6'b000010) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000010",
               {req_valid, fill_valid, busy, timeout_err, miss_ready, req_type});
    end
    tests++;
    if ({req_block_addr, fill_addr} !== '0 || {req_block_data, fill_data} !== '0) begin
      fails++; $display("FAIL reset_data: got addr %h/%h data %h/%h required all zero",
                        req_block_addr, fill_addr, req_block_data, fill_data);
    end
    rst = 1'b0; miss_valid = 1'b0; miss_wb_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || miss_ready !== 1'b1 || req_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy=%b miss_ready=%b req_valid=%b required 0 1 0",
                        busy, miss_ready, req_valid);
    end
  endtask

  task automatic test_clean_miss();
    run_miss("clean_miss", 1'b0, '0, '0, main_mem_block_addr_t'(32'h10), 0, 0, 2,
             {(BLOCK_DATA_W/8){8'hA5}});
  endtask

  task automatic test_dirty_miss();
    run_miss("dirty_miss", 1'b1, main_mem_block_addr_t'(32'h22), rand_data(),
             main_mem_block_addr_t'(32'h10), 0, 0, 1, rand_data());
  endtask

  task automatic test_wb_stall();
    run_miss("wb_stall", 1'b1, main_mem_block_addr_t'(32'h33), rand_data(),
             main_mem_block_addr_t'(32'h44), 5, 0, 1, rand_data());
  endtask

  task automatic test_spurious_and_busy();
    main_mem_block_addr_t fa1, fa2, reads[$];
    block_data_t          rd1, rd2;
    int acc[$], fills[$];
    int read_cyc, nfill;
    fa1 = rand_addr(); fa2 = rand_addr(); rd1 = rand_data(); rd2 = rand_data();
    resp_valid = 1'b1; resp_block_data = rand_data();
    tick(); tick();
    resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (fill_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL spurious_idle: fill_valid=%b busy=%b required 0 0", fill_valid, busy);
      end
      tick();
    end
    miss_valid = 1'b1; miss_wb_valid = 1'b0; miss_fill_addr = fa1; req_ready = 1'b1;
    read_cyc = -1; nfill = 0;
    for (int c = 0; c < 40 && nfill < 2; c++) begin
      if (fill_valid === 1'b1) begin
        fills.push_back(cyc);
        tests++;
        if (fill_addr !== (nfill == 0 ? fa1 : fa2) || fill_data !== (nfill == 0 ? rd1 : rd2)) begin
          fails++; $display("FAIL busy_fill%0d: got %h/%h required %h/%h", nfill, fill_addr,
                            fill_data, nfill == 0 ? fa1 : fa2, nfill == 0 ? rd1 : rd2);
        end
        nfill++;
      end
      resp_valid      = (read_cyc >= 0 && cyc == read_cyc + 1);
      resp_block_data = (reads.size() == 1) ? rd1 : rd2;
      if (req_valid === 1'b1) begin reads.push_back(req_block_addr); read_cyc = cyc; end
      if (miss_valid === 1'b1 && miss_ready === 1'b1) acc.push_back(cyc);
      tick();
      if (acc.size() == 1) miss_fill_addr = fa2;
      if (acc.size() >= 2) miss_valid = 1'b0;
    end
    miss_valid = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
    tests++;
    if (fills.size() != 2 || acc.size() != 2) begin
      fails++; $display("FAIL busy_counts: got fills=%0d accepts=%0d required 2 2", fills.size(), acc.size());
    end else begin
      tests++;
      if (acc[1] != fills[0] + 1) begin
        fails++; $display("FAIL busy_accept_cycle: got %0d required %0d", acc[1], fills[0] + 1);
      end
    end
    tests++;
    if (reads.size() != 2) begin
      fails++; $display("FAIL busy_reads: got %0d required 2", reads.size());
    end else if (reads[0] !== fa1 || reads[1] !== fa2) begin
      fails++; $display("FAIL busy_read_order: got %h,%h required %h,%h", reads[0], reads[1], fa1, fa2);
    end
  endtask

  task automatic test_reset_fill_wait();
    bit saw = 1'b0;
    miss_valid = 1'b1; miss_wb_valid = 1'b0; miss_fill_addr = rand_addr();
    tick();
    miss_valid = 1'b0; req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({req_valid, fill_valid, busy, timeout_err, miss_ready, req_type} !== 6'b000010 ||
        {req_block_addr, fill_addr} !== '0 || {req_block_data, fill_data} !== '0) begin
      fails++; $display("FAIL rst_fill_wait: flags %b addr %h data %h required 000010 and zeros",
                        {req_valid, fill_valid, busy, timeout_err, miss_ready, req_type},
                        req_block_addr, fill_data);
    end
    resp_valid = 1'b1; resp_block_data = rand_data();
    tick();
    resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fill_valid === 1'b1 || busy !== 1'b0) saw = 1'b1;
      tick();
    end
    tests++;
    if (saw) begin
      fails++; $display("FAIL rst_late_resp: got fill or busy after reset required none");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_miss("random", 1'($urandom), rand_addr(), rand_data(), rand_addr(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 5)), rand_data());
    end
  endtask

`ifdef DCACHE_MISS_TIMEOUT_EN
  task automatic test_timeout();
    bit saw = 1'b0;
    miss_valid = 1'b1; miss_wb_valid = 1'b0; miss_fill_addr = rand_addr(); resp_valid = 1'b0;
    tick();
    miss_valid = 1'b0; req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL timeout_early: cycle %0d err=%b busy=%b required 0 1", i, timeout_err, busy);
      end
      if (fill_valid === 1'b1) saw = 1'b1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || miss_ready !== 1'b1) begin
        fails++; $display("FAIL timeout_hold: err=%b busy=%b miss_ready=%b required 1 0 1",
                          timeout_err, busy, miss_ready);
      end
      if (fill_valid === 1'b1) saw = 1'b1;
      tick();
    end
    tests++;
    if (saw) begin
      fails++; $display("FAIL timeout_fill: got fill pulse required none");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL timeout_clear: got %b required 0", timeout_err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_fill_addr = '0; miss_wb_valid = 1'b0;
    miss_wb_addr = '0; miss_wb_data = '0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_block_data = '0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wb_stall();
    test_spurious_and_busy();
    test_reset_fill_wait();
    test_random();
`ifdef DCACHE_MISS_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
